// File: rtl/tx_frame_streamer_pkg.sv
// Shared types and constants for the frame-to-UART transmit path.
// The sync header bytes are only used when TX_FRAME_HEADER_EN is defined.
package tx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        SEND    = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [7:0] SYNC_BYTE0 = 8'hAA;
    localparam logic [7:0] SYNC_BYTE1 = 8'h55;

endpackage

// File: rtl/tx_frame_streamer_if.sv
// Byte stream from the frame streamer to the UART transmitter.
// Handshake: a byte moves on a rising edge where tx_valid && tx_ready; while tx_valid is
// high and tx_ready low, tx_data holds; tx_ready while tx_valid is low has no effect.
interface tx_frame_streamer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/tx_frame_streamer_serializer.sv
// pixel_byte_serializer: parallel-load shift register that emits bytes MSB-first
// under valid/ready; load_last_idx_i sets how many bytes the loaded word holds.
module pixel_byte_serializer #(
    parameter int RGB_WIDTH = 24,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [RGB_WIDTH-1:0] load_data_i,
    input  logic [IDX_W-1:0]     load_last_idx_i,
    tx_frame_streamer_if.master  tx,
    output logic                 last_byte_accepted_o
);

    logic [RGB_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 valid_q, valid_d;
    logic                 xfer;

    assign xfer                 = valid_q && tx.tx_ready;
    assign last_byte_accepted_o = xfer && (idx_q == last_q);
    assign tx.tx_data           = shift_q[RGB_WIDTH-1 -: 8];
    assign tx.tx_valid          = valid_q;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = load_data_i;
            idx_d   = '0;
            last_d  = load_last_idx_i;
            valid_d = 1'b1;
        end else if (xfer) begin
            if (idx_q == last_q) begin
                valid_d = 1'b0;
            end else begin
                // Next byte is presented the cycle after the transfer, so valid never drops.
                shift_d = shift_q << 8;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/tx_frame_streamer.sv
// Drains a frame from a 1-cycle-latency pixel RAM and streams it as MSB-first bytes.
// Define TX_FRAME_HEADER_EN to prefix each frame with sync bytes 0xAA 0x55.
module tx_frame_streamer
    import tx_frame_pkg::*;
#(
    parameter int RGB_WIDTH       = 24,
    parameter int IMG_WIDTH       = 80,
    parameter int IMG_HEIGHT      = 120,
    parameter int TOTAL_PIXELS    = IMG_WIDTH * IMG_HEIGHT,
    parameter int ADDR_WIDTH      = $clog2(TOTAL_PIXELS),
    parameter int BYTES_PER_PIXEL = RGB_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_done,
    output logic                  oe,
    output logic [ADDR_WIDTH-1:0] rAddr,
    input  logic [RGB_WIDTH-1:0]  imgData,
    tx_frame_streamer_if.master   tx,
    output logic                  busy,
    output logic                  o_tx_done,
    output state_e                dbg_state_o
);

    localparam int IDX_W = (BYTES_PER_PIXEL > 2) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(TOTAL_PIXELS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pix_q, pix_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  ser_load;
    logic [RGB_WIDTH-1:0]  ser_data;
    logic [IDX_W-1:0]      ser_last;
    logic                  last_acc;

    pixel_byte_serializer #(
        .RGB_WIDTH (RGB_WIDTH),
        .IDX_W     (IDX_W)
    ) u_ser (
        .clk                  (clk),
        .reset                (reset),
        .load_i               (ser_load),
        .load_data_i          (ser_data),
        .load_last_idx_i      (ser_last),
        .tx                   (tx),
        .last_byte_accepted_o (last_acc)
    );

    // Outputs are registered, so each transition sets what the next state drives.
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        raddr_d  = raddr_q;
        oe_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ser_load = 1'b0;
        ser_data = imgData;
        ser_last = IDX_W'(BYTES_PER_PIXEL - 1);
        unique case (state_q)
            IDLE: begin
                if (frame_done) begin
                    busy_d = 1'b1;
                    pix_d  = '0;
`ifdef TX_FRAME_HEADER_EN
                    // Header word is left-aligned so it shifts out through the same byte lane.
                    state_d  = HEADER;
                    ser_load = 1'b1;
                    ser_data = RGB_WIDTH'({SYNC_BYTE0, SYNC_BYTE1}) << (RGB_WIDTH - 16);
                    ser_last = IDX_W'(1);
`else
                    state_d = READ;
                    oe_d    = 1'b1;
                    raddr_d = '0;
`endif
                end
            end
`ifdef TX_FRAME_HEADER_EN
            HEADER: begin
                if (last_acc) begin
                    state_d = READ;
                    oe_d    = 1'b1;
                    raddr_d = pix_q;
                end
            end
`endif
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                ser_load = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                if (last_acc) begin
                    if (pix_q == LAST_PIX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        raddr_d = '0;
                        pix_d   = '0;
                    end else begin
                        state_d = READ;
                        pix_d   = pix_q + 1'b1;
                        raddr_d = pix_q + 1'b1;
                        oe_d    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pix_q   <= '0;
            raddr_q <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            raddr_q <= raddr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oe          = oe_q;
    assign rAddr       = raddr_q;
    assign busy        = busy_q;
    assign o_tx_done   = done_q;
    assign dbg_state_o = state_q;

endmodule
